enco4to2_pipe: RTL and testbench
================================

ENCO4TO2_PIPE -- requirements
Module: enco4to2_pipe

Interface
REQ-001 Parameter PRIO_HIGH, default 1, meaning 1 = highest set bit wins and 0 = lowest set bit wins.
REQ-002 Parameter ERR_W, default 8, meaning width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input word d is presented.
REQ-006 in_ready  output  1  block can accept a word; registered.
REQ-007 d  input  4  word to encode.
REQ-008 out_valid  output  1  head result is valid.
REQ-009 out_ready  input  1  consumer takes the head result.
REQ-010 y  output  2  encoded index of the head result.
REQ-011 onehot_ok  output  1  head source word had exactly one bit set.
REQ-012 zero  output  1  head source word was 4'b0000.
REQ-013 err_cnt  output  ERR_W  count of accepted words with onehot_ok=0; saturating.

Function
REQ-014 Accept occurs when in_valid=1 and in_ready=1 on the same edge; pop occurs when out_valid=1 and out_ready=1 on the same edge.
REQ-015 Encoding with PRIO_HIGH=1: y is the highest set bit index (4'b1010 gives 2'd3; 4'b0110 gives 2'd2).
REQ-016 Encoding with PRIO_HIGH=0: y is the lowest set bit index (4'b1010 gives 2'd1).
REQ-017 d=4'b0000 gives y=2'd0, zero=1 and onehot_ok=0.
REQ-018 Buffer is 2 entries, each holding {y, onehot_ok, zero}; results leave in acceptance order.
REQ-019 Buffer FSM states are EMPTY, ONE and TWO.
- EMPTY: accept goes to ONE.
- ONE: accept with no pop goes to TWO; pop with no accept goes to EMPTY; accept with pop stays ONE, and the new result becomes head on the next cycle.
- TWO: pop goes to ONE, and the second entry becomes head.
REQ-020 Latency: a word accepted in EMPTY is presented with out_valid=1 on the cycle after acceptance.
REQ-021 out_valid=1 exactly in states ONE and TWO.
REQ-022 in_ready is registered and is 0 exactly in state TWO, so the block accepts nothing in TWO even when out_ready=1.
REQ-023 When out_valid=1 and out_ready=0, y, onehot_ok and zero are held stable.
REQ-024 err_cnt increments by 1 on each accept whose word is not one-hot (zero or multi-bit).
REQ-025 err_cnt holds at all-ones once reached and never wraps.
REQ-026 err_cnt updates on the accept edge, independent of when the result is popped.
REQ-027 d is ignored when the word is not accepted.

Reset
REQ-028 While rst=1, the FSM is EMPTY and out_valid=0, y=0, onehot_ok=0, zero=0, err_cnt=0 and in_ready=0.
REQ-029 in_ready=1 on the first cycle after rst deasserts.
REQ-030 rst asserted mid-operation discards all buffered results, and no partially buffered result is presented afterward.

Structure
REQ-031 Package enco_pkg holds the FSM state enum (EMPTY, ONE, TWO), the constants IN_W=4 and CODE_W=2, and the buffer entry struct {y, onehot_ok, zero}.
REQ-032 Combinational encoding lives in sub-module enco4to2_core (inputs d and PRIO_HIGH; outputs y, onehot_ok, zero).
REQ-033 Buffering, FSM and the counter live in enco4to2_pipe.

Verification
REQ-034 Scenario 1, single word: after reset, d=4'b0100 with in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, y=2, onehot_ok=1, zero=0, err_cnt=0.
REQ-035 Scenario 2, exhaustive one-hot: d=0001, 0010, 0100, 1000 back-to-back, out_ready=1 -> y=0,1,2,3 on consecutive cycles, in_ready stays 1.
REQ-036 Scenario 3, backpressure: out_ready=0, send 4'b0001 then 4'b1000 -> state TWO, in_ready=0, a third word 4'b0010 is not accepted; set out_ready=1 -> y=0, then y=3, then in_ready=1.
REQ-037 Scenario 4, errors and saturation: with PRIO_HIGH=1, send 4'b0000 and 4'b1011 -> y=0 with zero=1, then y=3 with onehot_ok=0, err_cnt=2; with ERR_W=2, send 5 non-one-hot words -> err_cnt=3.
REQ-038 Scenario 5, low priority: with PRIO_HIGH=0, d=4'b1100 -> y=2, onehot_ok=0.
REQ-039 Scenario 6, reset mid-operation: in state TWO, assert rst for 1 cycle -> out_valid=0, err_cnt=0, in_ready=1 the next cycle, and no stale result is presented.

Source files
------------

// File: rtl/enco_pkg.sv
// Shared types and constants for the 4-to-2 priority encoder with a 2-entry result buffer.
package enco_pkg;

    localparam int IN_W   = 4;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] y;
        logic              onehot_ok;
        logic              zero;
    } entry_t;

endpackage

// File: rtl/enco4to2_core.sv
// Combinational 4-to-2 priority encoder; PRIO_HIGH selects whether the highest or lowest set bit wins.
module enco4to2_core
    import enco_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic [IN_W-1:0]   d,
    output logic [CODE_W-1:0] y,
    output logic              onehot_ok,
    output logic              zero
);

    // Scan order makes the last matching bit win: ascending for high priority, descending for low.
    always_comb begin
        y = '0;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < IN_W; i++) begin
                if (d[i]) y = CODE_W'(i);
            end
        end else begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (d[i]) y = CODE_W'(i);
            end
        end
    end

    assign zero      = (d == '0);
    assign onehot_ok = !zero && ((d & (d - 1'b1)) == '0);

endmodule

// File: rtl/enco4to2_pipe.sv
// Encoder with a 2-entry in-order result buffer, registered in_ready and a saturating error counter.
module enco4to2_pipe
    import enco_pkg::*;
#(
    parameter int PRIO_HIGH = 1,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] y,
    output logic              onehot_ok,
    output logic              zero,
    output logic [ERR_W-1:0]  err_cnt
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t state_q, state_d;
    entry_t enc_p0;
    entry_t head_p1, tail_p1;
    logic   accept, pop;

    enco4to2_core #(.PRIO_HIGH(PRIO_HIGH)) u_core (
        .d         (d),
        .y         (enc_p0.y),
        .onehot_ok (enc_p0.onehot_ok),
        .zero      (enc_p0.zero)
    );

    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state_q != EMPTY);
    assign y         = head_p1.y;
    assign onehot_ok = head_p1.onehot_ok;
    assign zero      = head_p1.zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = TWO;
                else if (pop && !accept) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Stage p0 -> p1: combinational result lands in head or tail depending on occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            in_ready <= 1'b0;
            head_p1  <= '0;
            tail_p1  <= '0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != TWO);
            if (accept && !enc_p0.onehot_ok) err_cnt <= sat_inc(err_cnt);
            case (state_q)
                EMPTY: if (accept) head_p1 <= enc_p0;
                ONE: begin
                    if (accept && pop) head_p1 <= enc_p0;
                    else if (accept)   tail_p1 <= enc_p0;
                end
                TWO:     if (pop) head_p1 <= tail_p1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enco4to2_pipe.sv
// Directed bench: default instance, low-priority instance and a 2-bit error counter instance share one stimulus.
module tb_enco4to2_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] d;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_onehot_ok, a_zero;
    logic [1:0] a_y;
    logic [7:0] a_err;
    logic       b_in_ready, b_out_valid, b_onehot_ok, b_zero;
    logic [1:0] b_y;
    logic [7:0] b_err;
    logic       c_in_ready, c_out_valid, c_onehot_ok, c_zero;
    logic [1:0] c_y;
    logic [1:0] c_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enco4to2_pipe #(.PRIO_HIGH(1), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .d(d),
        .out_valid(a_out_valid), .out_ready(out_ready), .y(a_y),
        .onehot_ok(a_onehot_ok), .zero(a_zero), .err_cnt(a_err)
    );

    enco4to2_pipe #(.PRIO_HIGH(0), .ERR_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .d(d),
        .out_valid(b_out_valid), .out_ready(out_ready), .y(b_y),
        .onehot_ok(b_onehot_ok), .zero(b_zero), .err_cnt(b_err)
    );

    enco4to2_pipe #(.PRIO_HIGH(1), .ERR_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .d(d),
        .out_valid(c_out_valid), .out_ready(out_ready), .y(c_y),
        .onehot_ok(c_onehot_ok), .zero(c_zero), .err_cnt(c_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; d = 4'b0000; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_y",         32'(a_y), 0);
        chk("rst_onehot",    32'(a_onehot_ok), 0);
        chk("rst_zero",      32'(a_zero), 0);
        chk("rst_err",       32'(a_err), 0);
        chk("rst_in_ready",  32'(a_in_ready), 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(a_in_ready), 1);
        chk("post_rst_out_valid", 32'(a_out_valid), 0);

        // Scenario 1: single word
        in_valid = 1'b1; d = 4'b0100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("s1_out_valid", 32'(a_out_valid), 1);
        chk("s1_y",         32'(a_y), 2);
        chk("s1_onehot",    32'(a_onehot_ok), 1);
        chk("s1_zero",      32'(a_zero), 0);
        chk("s1_err",       32'(a_err), 0);
        step();
        chk("s1_drained", 32'(a_out_valid), 0);

        // Scenario 2: one-hot words back-to-back with the consumer always ready
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 4'(1 << i);
            step();
            chk("s2_out_valid", 32'(a_out_valid), 1);
            chk("s2_y",         32'(a_y), 32'(i));
            chk("s2_in_ready",  32'(a_in_ready), 1);
            chk("s2_lowprio_y", 32'(b_y), 32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("s2_drained", 32'(a_out_valid), 0);

        // Scenario 3: backpressure fills the buffer
        out_ready = 1'b0; in_valid = 1'b1; d = 4'b0001;
        step();
        chk("s3_one_in_ready", 32'(a_in_ready), 1);
        d = 4'b1000;
        step();
        chk("s3_two_in_ready",  32'(a_in_ready), 0);
        chk("s3_two_out_valid", 32'(a_out_valid), 1);
        chk("s3_two_y",         32'(a_y), 0);
        d = 4'b0010;
        step();
        chk("s3_held_y",        32'(a_y), 0);
        chk("s3_held_in_ready", 32'(a_in_ready), 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("s3_second_y",     32'(a_y), 3);
        chk("s3_second_valid", 32'(a_out_valid), 1);
        chk("s3_in_ready",     32'(a_in_ready), 1);
        step();
        chk("s3_no_third", 32'(a_out_valid), 0);
        chk("s3_err",      32'(a_err), 0);

        // Unaccepted non-one-hot word must leave the counter alone
        d = 4'b0000;
        step();
        chk("ignored_d_err", 32'(a_err), 0);

        // Scenario 4: error counting and saturation
        in_valid = 1'b1; d = 4'b0000;
        step();
        chk("s4_zero_y",      32'(a_y), 0);
        chk("s4_zero_flag",   32'(a_zero), 1);
        chk("s4_zero_onehot", 32'(a_onehot_ok), 0);
        chk("s4_err1",        32'(a_err), 1);
        d = 4'b1011;
        step();
        chk("s4_multi_y",      32'(a_y), 3);
        chk("s4_multi_onehot", 32'(a_onehot_ok), 0);
        chk("s4_multi_zero",   32'(a_zero), 0);
        chk("s4_err2",         32'(a_err), 2);
        chk("s4_lowprio_y",    32'(b_y), 0);
        d = 4'b0011;
        step();
        chk("s4_sat_err3", 32'(c_err), 3);
        d = 4'b0110;
        step();
        chk("s4_sat_hold4", 32'(c_err), 3);
        d = 4'b1111;
        step();
        chk("s4_sat_hold5", 32'(c_err), 3);
        chk("s4_wide_err5", 32'(a_err), 5);

        // Scenario 5: low priority selects the lowest set bit
        d = 4'b1100;
        step();
        in_valid = 1'b0;
        chk("s5_low_y",      32'(b_y), 2);
        chk("s5_low_onehot", 32'(b_onehot_ok), 0);
        chk("s5_high_y",     32'(a_y), 3);
        chk("s5_err6",       32'(a_err), 6);
        step();

        // Scenario 6: reset while the buffer is full
        out_ready = 1'b0; in_valid = 1'b1; d = 4'b0001;
        step();
        d = 4'b0010;
        step();
        chk("s6_full_in_ready", 32'(a_in_ready), 0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("s6_rst_out_valid", 32'(a_out_valid), 0);
        chk("s6_rst_err",       32'(a_err), 0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("s6_in_ready",  32'(a_in_ready), 1);
        chk("s6_out_valid", 32'(a_out_valid), 0);
        step();
        chk("s6_no_stale", 32'(a_out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
